// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with same-cycle hits and a
// word-ordered line refill from backing memory on a miss.
module icache_dm #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SETS       = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
  input  logic                     invalidate,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic                     stall,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_rvalid
);

  localparam int unsigned OFF_W   = 2;
  localparam int unsigned WORD_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W   = $clog2(NUM_SETS);
  localparam int unsigned IDX_LSB = OFF_W + WORD_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
  localparam int unsigned TAG_W   = ADDRESS_WIDTH - TAG_LSB;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_FILL_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [WORD_W-1:0]          beat_q, beat_d;
  logic                       mem_req_q, mem_req_d;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [NUM_SETS-1:0]        valid_q, valid_d;
  logic                       kill_q, kill_d;

  logic [DATA_WIDTH-1:0]      data_q [NUM_SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0]           tag_q  [NUM_SETS];

  logic [WORD_W-1:0]          req_word;
  logic [IDX_W-1:0]           req_idx;
  logic [TAG_W-1:0]           req_tag;
  logic [IDX_W-1:0]           fill_idx;
  logic [TAG_W-1:0]           fill_tag;
  logic                       hit_c;
  logic                       fill_we;
  logic                       tag_we;
  logic                       unused_c;

  // Address split for the lookup and for the latched refill line
  assign req_word = fetch_addr[IDX_LSB-1:OFF_W];
  assign req_idx  = fetch_addr[TAG_LSB-1:IDX_LSB];
  assign req_tag  = fetch_addr[ADDRESS_WIDTH-1:TAG_LSB];
  assign fill_idx = mem_addr_q[TAG_LSB-1:IDX_LSB];
  assign fill_tag = mem_addr_q[ADDRESS_WIDTH-1:TAG_LSB];
  assign unused_c = ^fetch_addr[OFF_W-1:0];

  // Same-cycle lookup so hits match fetch timing
  assign hit_c    = fetch_req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign instr    = hit_c ? data_q[req_idx][req_word] : '0;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      kill_q     <= kill_d;
    end
  end

  // Data and tag storage; validity is tracked separately so no reset needed
  always_ff @(posedge clk) begin
    if (fill_we) data_q[fill_idx][beat_q] <= mem_rdata;
    if (tag_we)  tag_q[fill_idx]          <= fill_tag;
  end

  // Next-state, refill sequencing and stall generation
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    kill_d     = kill_q;
    fill_we    = 1'b0;
    tag_we     = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fetch_req && !hit_c) begin
          stall            = 1'b1;
          mem_addr_d       = {req_tag, req_idx, IDX_LSB'(0)};
          valid_d[req_idx] = 1'b0;
          mem_req_d        = 1'b1;
          beat_d           = '0;
          kill_d           = 1'b0;
          state_d          = S_REFILL;
        end
      end
      S_REFILL: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          mem_req_d = 1'b0;
          fill_we   = 1'b1;
          beat_d    = WORD_W'(beat_q + 1'b1);
          if (beat_q == LAST_BEAT) begin
            tag_we  = 1'b1;
            if (!kill_q) valid_d[fill_idx] = 1'b1;
            state_d = S_FILL_DONE;
          end
        end
      end
      S_FILL_DONE: begin
        stall   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // fence.i wipes every line; an in-flight line must not come back valid
    if (invalidate) begin
      valid_d = '0;
      if (state_q != S_IDLE) kill_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: expected instructions are queued at issue
// and checked by an independent monitor whenever the DUT delivers one.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        invalidate;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  icache_dm dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .invalidate (invalidate),
    .instr      (instr),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivered instruction is matched against the queue head
  always @(negedge clk) begin
    if (!rst && fetch_req && !stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_instr", instr, 32'hDEAD_BEEF);
      end else begin
        check("instr", instr, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_fetch(input logic [31:0] addr, input logic [31:0] exp, input bit push);
    if (push) exp_q.push_back(exp);
    fetch_req  = 1'b1;
    fetch_addr = addr;
  endtask

  // Expect a hit this cycle, then release the request
  task automatic finish_hit();
    @(negedge clk);
    check("hit_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
    start_fetch(addr, exp, 1'b1);
    finish_hit();
  endtask

  // Entered in the miss cycle; returns in the first IDLE cycle after FILL_DONE
  task automatic miss_refill(input logic [31:0] base, input logic [127:0] line,
                             input logic [15:0] gaps, input int inv_beat);
    int stalled = 0;
    int gap_sum = 0;
    @(negedge clk);
    check("miss_stall",  {31'd0, stall},   32'd1);
    check("miss_instr",  instr,            32'd0);
    check("miss_memreq", {31'd0, mem_req}, 32'd0);
    if (stall) stalled++;
    for (int b = 0; b < 4; b++) begin
      int ng = int'(gaps[b*4 +: 4]);
      gap_sum += ng;
      for (int g = 0; g < ng; g++) begin
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        invalidate = 1'b0;
        @(negedge clk);
        check("gap_stall",  {31'd0, stall},   32'd1);
        check("gap_memreq", {31'd0, mem_req}, (b == 0) ? 32'd1 : 32'd0);
        if (stall) stalled++;
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = line[b*32 +: 32];
      invalidate = (b == inv_beat);
      @(negedge clk);
      check("beat_stall",  {31'd0, stall},   32'd1);
      check("beat_memreq", {31'd0, mem_req}, (b == 0) ? 32'd1 : 32'd0);
      check("mem_addr",    mem_addr,         base);
      if (stall) stalled++;
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    invalidate = 1'b0;
    @(negedge clk);
    check("filldone_stall", {31'd0, stall}, 32'd1);
    if (stall) stalled++;
    @(posedge clk); #1;
    check("stall_cycles", 32'(stalled), 32'(6 + gap_sum));
  endtask

  initial begin
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    invalidate = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_stall",    {31'd0, stall},   32'd0);
    check("rst_instr",    instr,            32'd0);
    check("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr,         32'd0);
    @(posedge clk); #1;

    // Cold miss on 0x0, then same-cycle hits across the line
    start_fetch(32'h0, 32'h11, 1'b1);
    miss_refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 16'h0000, -1);
    finish_hit();
    fetch_hit(32'h4, 32'h22);
    fetch_hit(32'h8, 32'h33);
    fetch_hit(32'hC, 32'h44);

    // Conflict on index 0
    start_fetch(32'h400, 32'h55, 1'b1);
    miss_refill(32'h400, {32'h88, 32'h77, 32'h66, 32'h55}, 16'h0000, -1);
    finish_hit();
    fetch_hit(32'h40C, 32'h88);
    start_fetch(32'h0, 32'h11, 1'b1);
    miss_refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 16'h0000, -1);
    finish_hit();

    // Refill with beats on refill cycles 1,4,5,9
    start_fetch(32'h48, 32'hB2, 1'b1);
    miss_refill(32'h40, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 16'h3020, -1);
    finish_hit();
    fetch_hit(32'h40, 32'hB0);
    fetch_hit(32'h44, 32'hB1);
    fetch_hit(32'h4C, 32'hB3);

    // Invalidate mid-refill: line not installed, same PC misses again
    start_fetch(32'h100, 32'hD0, 1'b1);
    miss_refill(32'h100, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'h0000, 1);
    miss_refill(32'h100, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 16'h0000, -1);
    finish_hit();
    start_fetch(32'h0, 32'h11, 1'b1);
    miss_refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 16'h0000, -1);
    finish_hit();

    // Reset on the second refill beat; stray beats afterwards are ignored
    start_fetch(32'h300, 32'h0, 1'b0);
    @(negedge clk);
    check("rr_miss_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hE0;
    @(posedge clk); #1;
    mem_rdata  = 32'hE1;
    rst        = 1'b1;
    fetch_req  = 1'b0;
    @(posedge clk); #1;
    rst        = 1'b0;
    mem_rdata  = 32'hE2;
    @(negedge clk);
    check("rr_mem_req",  {31'd0, mem_req}, 32'd0);
    check("rr_stall",    {31'd0, stall},   32'd0);
    check("rr_mem_addr", mem_addr,         32'd0);
    @(posedge clk); #1;
    mem_rdata  = 32'hE3;
    @(negedge clk);
    check("rr_stray_stall",   {31'd0, stall},   32'd0);
    check("rr_stray_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    start_fetch(32'h0, 32'hA0, 1'b1);
    miss_refill(32'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'h0000, -1);
    finish_hit();
    start_fetch(32'h304, 32'hF1, 1'b1);
    miss_refill(32'h300, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 16'h0000, -1);
    finish_hit();

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
